// File: rtl/ritc_phase_scan_engine.sv
// ritc_phase_scan_engine: synchronises RITC capture lines and counts ones/edges on one selected line.
module ritc_phase_scan_engine #(
    parameter int NCH           = 3,
    parameter int NBITS         = 12,
    parameter int NCLK          = 3,
    parameter int CNT_WIDTH     = 16,
    parameter int SEL_WIDTH     = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int NLINES        = NCH*NBITS + NCLK + 1
) (
    input  logic                   user_clk_i,
    input  logic                   user_rst_i,
    input  logic [NCH*NBITS-1:0]   dat_in_i,
    input  logic [NCLK-1:0]        clk_in_i,
    input  logic                   vcdl_in_i,
    input  logic                   scan_start_i,
    input  logic [SEL_WIDTH-1:0]   scan_sel_i,
    input  logic [CNT_WIDTH-1:0]   scan_len_i,
    output logic                   scan_busy_o,
    output logic                   scan_done_o,
    output logic                   scan_err_o,
    output logic [CNT_WIDTH-1:0]   scan_ones_o,
    output logic [CNT_WIDTH-1:0]   scan_edges_o,
    output logic [NLINES-1:0]      lines_q_o
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DONE} state_t;
    state_t                 r_state;
    logic [NLINES-1:0]      r_sync1, r_sync2;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [CNT_WIDTH-1:0]   r_len, r_cnt, r_ones, r_edges, r_ones_o, r_edges_o;
    logic                   r_sel_bit, r_prev, r_first, r_busy, r_done, r_err;
    logic [NLINES-1:0]      w_lines;
    logic                   w_sel_bit, w_sel_bad;
    logic [CNT_WIDTH-1:0]   w_ones_nxt, w_edges_nxt;
    assign w_lines     = {vcdl_in_i, clk_in_i, dat_in_i};
    assign w_sel_bit   = (32'(r_sel) < NLINES) && r_sync2[r_sel];
    assign w_sel_bad   = 32'(scan_sel_i) >= NLINES;
    assign w_ones_nxt  = r_ones + CNT_WIDTH'(r_sel_bit);
    // the first accumulated sample has no predecessor inside the window
    assign w_edges_nxt = r_edges + CNT_WIDTH'(!r_first && (r_sel_bit != r_prev));
    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_state   <= S_IDLE;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sel     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_ones    <= '0;
            r_edges   <= '0;
            r_ones_o  <= '0;
            r_edges_o <= '0;
            r_sel_bit <= 1'b0;
            r_prev    <= 1'b0;
            r_first   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync1   <= w_lines;
            r_sync2   <= r_sync1;
            r_sel_bit <= w_sel_bit;
            case (r_state)
                S_IDLE: if (scan_start_i) begin
                    r_sel   <= scan_sel_i;
                    r_len   <= scan_len_i;
                    r_ones  <= '0;
                    r_edges <= '0;
                    if (w_sel_bad || scan_len_i == '0) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= w_sel_bad;
                        r_ones_o  <= '0;
                        r_edges_o <= '0;
                    end else begin
                        r_state <= S_SETTLE;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_WIDTH'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_ACCUM;
                        r_prev  <= r_sel_bit;
                        r_first <= 1'b1;
                        r_cnt   <= r_len - 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_ones  <= w_ones_nxt;
                    r_edges <= w_edges_nxt;
                    r_prev  <= r_sel_bit;
                    r_first <= 1'b0;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        r_ones_o  <= w_ones_nxt;
                        r_edges_o <= w_edges_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign scan_busy_o  = r_busy;
    assign scan_done_o  = r_done;
    assign scan_err_o   = r_err;
    assign scan_ones_o  = r_ones_o;
    assign scan_edges_o = r_edges_o;
    assign lines_q_o    = r_sync2;
endmodule
